// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sequencer sharing one UART transmitter
// Owns the tx_start/tx_done handshake, the inter-frame gap and the completion watchdog.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int IW        = 2,
  parameter int DBIT      = 8,
  parameter int CW        = 8,
  parameter int GAP_TICKS = 16,
  parameter int TO_TICKS  = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] din,
  output logic [NREQ-1:0]      ack,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_data,
  input  logic                 tx_done_tick,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 tx_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  localparam state_t        AFTER_FRAME = (GAP_TICKS == 0) ? IDLE : GAP;
  localparam logic [CW-1:0] TO_LAST     = CW'(TO_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, grant_n, ptr_after;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] ack_n;
  logic            start_n, err_n;
  logic [DBIT-1:0] data_n;
  logic            found;
  logic [IW-1:0]   winner;
  logic [DBIT-1:0] win_data;

  // Rotating priority: scan ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && i == (int'(ptr) + k) % NREQ) begin
          found    = 1'b1;
          winner   = IW'(i);
          win_data = din[i*DBIT +: DBIT];
        end
      end
    end
  end

  assign ptr_after = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant_id;
    data_n  = tx_data;
    ack_n   = '0;
    start_n = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          data_n  = win_data;
          grant_n = winner;
          ack_n   = NREQ'(1) << winner;
          state_n = START;
        end
      end
      START: begin
        start_n = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a timeout landing on the same clk.
        if (tx_done_tick) begin
          ptr_n   = ptr_after;
          cnt_n   = '0;
          state_n = AFTER_FRAME;
        end else if (s_tick) begin
          if (cnt == TO_LAST) begin
            err_n   = 1'b1;
            ptr_n   = ptr_after;
            cnt_n   = '0;
            state_n = AFTER_FRAME;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      GAP: begin
        if (s_tick) begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      grant_id <= grant_n;
      tx_data  <= data_n;
      ack      <= ack_n;
      tx_start <= start_n;
      tx_err   <= err_n;
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized frame-level check of uart_tx_arbiter
// Reference model tracks only the rotating pointer and frame rules.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4, IW = 2, DBIT = 8, CW = 8, GAP_TICKS = 16, TO_TICKS = 200;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_tick = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DBIT-1:0] din = '0;
  logic [NREQ-1:0]      ack;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_data;
  logic                 tx_done_tick = 1'b0;
  logic [IW-1:0]        grant_id;
  logic                 busy;
  logic                 tx_err;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IW(IW), .DBIT(DBIT), .CW(CW), .GAP_TICKS(GAP_TICKS), .TO_TICKS(TO_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .req(req), .din(din), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
    .grant_id(grant_id), .busy(busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  int ack_seen, start_seen, err_seen;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock with the given transmitter/tick inputs; outputs sampled 1ns after the edge.
  task automatic tick_clk(input bit s, input bit d);
    s_tick = s;
    tx_done_tick = d;
    @(posedge clk);
    #1;
    s_tick = 1'b0;
    tx_done_tick = 1'b0;
    if (tx_err) err_seen++;
    if (tx_start) start_seen++;
    if (ack != 0) ack_seen++;
  endtask

  task automatic idle_then_tick(input bit d);
    repeat ($urandom_range(0, 2)) tick_clk(1'b0, 1'b0);
    tick_clk(1'b1, d);
  endtask

  // mode 0: done before timeout, 1: watchdog timeout, 2: done on the timeout tick
  task automatic run_frame(input logic [NREQ-1:0] rq, input int mode, input bit hold,
                           input bit late_done, output int gid);
    int w, gap;
    logic [DBIT-1:0] exp_byte;
    ack_seen = 0; start_seen = 0; err_seen = 0;
    check("idle_busy", busy, 0);
    req = rq;
    din = $urandom;
    w = pick(rq, ptr_m);
    exp_byte = din[w*DBIT +: DBIT];
    tick_clk(1'b0, 1'b0);
    gid = grant_id;
    check("ack", ack, 1 << w);
    check("grant_id", grant_id, w);
    check("tx_data", tx_data, exp_byte);
    check("busy_grant", busy, 1);
    if (!hold) req = '0;
    tick_clk(1'b0, 1'b0);
    check("ack_drop", ack, 0);
    check("tx_start", tx_start, 1);
    if (mode == 0) begin
      repeat ($urandom_range(0, 150)) idle_then_tick(1'b0);
      tick_clk(1'($urandom_range(0, 1)), 1'b1);
    end else begin
      repeat (TO_TICKS - 1) idle_then_tick(1'b0);
      check("no_err_early", err_seen, 0);
      check("busy_wait", busy, 1);
      tick_clk(1'b1, mode == 2);
      check("err_on_last_tick", tx_err, (mode == 1) ? 1 : 0);
    end
    check("tx_data_hold", tx_data, exp_byte);
    ptr_m = (w + 1) % NREQ;
    gap = 0;
    for (int t = 1; t <= GAP_TICKS + 4 && busy; t++) begin
      repeat ($urandom_range(0, 1)) tick_clk(1'b0, 1'b0);
      tick_clk(1'b1, late_done && t == GAP_TICKS - 2);
      gap = t;
    end
    check("gap_ticks", gap, GAP_TICKS);
    check("err_count", err_seen, (mode == 1) ? 1 : 0);
    check("start_count", start_seen, 1);
    check("ack_count", ack_seen, 1);
    check("idle_grant_hold", grant_id, w);
    check("idle_data_hold", tx_data, exp_byte);
  endtask

  initial begin
    int gid, mode;
    #12;
    check("rst_ack", ack, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      run_frame(4'b1111, 0, 1'b1, 1'b0, gid);
      check("rr_order", gid, k % NREQ);
    end

    run_frame(4'b0100, 0, 1'b0, 1'b0, gid);
    check("single_req", gid, 2);

    run_frame(4'b1000, 0, 1'b0, 1'b0, gid);
    check("serve_3", gid, 3);
    run_frame(4'b1001, 0, 1'b0, 1'b0, gid);
    check("wrap_to_0", gid, 0);

    run_frame(4'b1111, 1, 1'b0, 1'b1, gid);
    check("timeout_grant", gid, 1);
    run_frame(4'b1111, 0, 1'b0, 1'b0, gid);
    check("after_timeout", gid, 2);

    run_frame(4'b0001, 2, 1'b0, 1'b0, gid);
    check("simul_grant", gid, 0);

    req = 4'b0100;
    din = $urandom;
    tick_clk(1'b0, 1'b0);
    tick_clk(1'b0, 1'b0);
    req = '0;
    repeat (5) tick_clk(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_ack", ack, 0);
    check("arst_tx_start", tx_start, 0);
    check("arst_busy", busy, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_grant_id", grant_id, 0);
    check("arst_tx_err", tx_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ptr_m = 0;
    ack_seen = 0; start_seen = 0;
    repeat (3) tick_clk(1'b0, 1'b1);
    check("no_ack_after_reset", ack_seen, 0);
    check("no_start_after_reset", start_seen, 0);
    run_frame(4'b1010, 0, 1'b0, 1'b0, gid);
    check("post_reset_grant", gid, 1);

    for (int k = 0; k < 14; k++) begin
      mode = $urandom_range(0, 4);
      mode = (mode <= 2) ? 0 : mode - 2;
      run_frame(4'($urandom_range(1, 15)), mode, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), gid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one UART transmitter between NREQ requesters, e.g. floor panels, cabin controller and status logger.
- Owns the transmitter start/done handshake.
- Enforces an inter-frame gap measured in baud ticks from the system mod-M tick generator.
- Runs a watchdog that recovers if the transmitter never reports completion.

Parameters:
NREQ, 4, number of requesters (2..8)
IW, 2, width of requester index; must satisfy 2**IW >= NREQ
DBIT, 8, data bits per frame
CW, 8, width of gap/timeout tick counter
GAP_TICKS, 16, s_tick periods of idle line between frames (16 = one bit time at 16x oversampling); 0 = no gap
TO_TICKS, 200, s_tick periods allowed between tx_start and tx_done_tick before abort; must be < 2**CW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tick  in  1  one-clk baud tick from mod-M counter
req  in  NREQ  request level per requester; held until its ack
din  in  NREQ*DBIT  packed bytes; requester i at [i*DBIT +: DBIT]
ack  out  NREQ  one-clk pulse: requester's byte latched, may drop req/change din
tx_start  out  1  one-clk pulse to transmitter
tx_data  out  DBIT  byte to transmit; stable from tx_start until next grant
tx_done_tick  in  1  one-clk pulse from transmitter at end of stop bit
grant_id  out  IW  index of current/last owner
busy  out  1  high whenever state != IDLE
tx_err  out  1  one-clk pulse on watchdog timeout

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state = IDLE.
  - ack, tx_start, tx_err, busy = 0.
  - tx_data = 0, grant_id = 0.
  - rr pointer = 0, tick counter = 0.
  - Reset mid-frame abandons the grant; no ack or tx_start is issued afterwards.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, GAP.
- IDLE:
  - req sampled each clk.
  - If req != 0, select the first set bit searching ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - On that edge: tx_data <= din slice of the winner; grant_id <= winner; ack[winner] <= 1; go to START.
  - If req == 0, stay in IDLE.
- START:
  - ack deasserts.
  - tx_start <= 1 for exactly one clk; tick counter cleared; go to WAIT.
- Latency: req seen in IDLE -> ack one clk later -> tx_start two clks later.
- WAIT:
  - tx_done_tick: ptr <= (grant_id+1) mod NREQ (wraps NREQ-1 -> 0); counter cleared; go to GAP, or to IDLE if GAP_TICKS == 0.
  - Otherwise each s_tick increments the counter.
  - Timeout: when the counter == TO_TICKS-1 and s_tick is high, pulse tx_err; ptr advances as above; go to GAP (or IDLE if GAP_TICKS == 0).
- Simultaneous tx_done_tick and timeout tick in WAIT: done wins, tx_err is not pulsed.
- GAP:
  - Each s_tick increments the counter.
  - When the counter == GAP_TICKS-1 and s_tick is high, go to IDLE.
  - First re-arbitration is on the next clk.
- tx_done_tick is ignored in IDLE, START and GAP.
- req is ignored outside IDLE; requesters hold req. A requester that drops req before ack simply loses its turn, with no error.
- ack is never issued to a requester whose req bit is 0 on the sampling edge.
- Fairness: with all req held high, grant order is 0,1,2,…,NREQ-1,0,… ; no requester waits more than NREQ-1 frames.
- grant_id and tx_data hold their last values while in IDLE.

Test Plan:
- Single request, GAP_TICKS=16: req=4'b0100, din[2]=8'hA5 -> ack=4'b0100 one clk later; tx_start one clk after that with tx_data=8'hA5, grant_id=2; busy high until 16 s_ticks after tx_done_tick.
- Round robin: req=4'b1111 held, each ack'd requester re-raises req -> grant order 0,1,2,3,0; each ack pulse exactly 1 clk; 4 tx_start pulses per 4 tx_done_tick.
- Pointer wrap: serve requester 3 (ptr -> 0), then req=4'b1001 -> requester 0 granted before 3.
- Timeout: tx_start, no tx_done_tick, 200 s_ticks -> tx_err pulses once on the 200th tick; after GAP the next requester is served; a tx_done_tick arriving late in GAP is ignored.
- Simultaneous edge: tx_done_tick and the 200th s_tick in the same clk -> no tx_err; state goes to GAP.
- Async reset asserted in WAIT: all outputs 0 immediately; after release with req=4'b0010 -> grant to requester 1 (ptr reset to 0, search starts at 0).
